// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline hazard / stall controller for a five-stage pipeline.
//
// Resolves IF fetch waits, load-use hazards, multi-cycle divides in EX,
// data-memory waits in MEM and exception/ERET flushes. It produces a hold
// (stall) and a clear-to-bubble (refresh) strobe for every segment register.
// All strobes are combinational from the current state, div_cnt and the
// current inputs, so a hazard is covered in the cycle it is first seen.
//
// Ports
//   clk                     clock, rising edge
//   resetn                  asynchronous active-low reset; forces outputs to 0
//   fetch_pend              IF instruction not yet returned this cycle
//   id_load_use             ID reads the destination of the load in EX
//   ex_div_start            DIV/DIVU in EX, not yet started
//   mem_data_req            MEM issues a data-memory access this cycle
//   mem_data_ok             data-memory access completes this cycle
//   exc_flush               exception / ERET committed in MEM this cycle
//   pc_stall                hold the PC
//   *_stall                 hold the named segment register
//   *_refresh               clear the named segment register to a bubble
//   ctrl_state              IDLE=0, MEM_WAIT=1, DIV_WAIT=2, FLUSH=3
//
// Data-memory handshake: mem_data_req marks a request presented in MEM;
// mem_data_ok marks its completion. A cycle with req=1 and ok=0 is a miss
// and stalls; ok=1 in the same cycle as req completes without stalling.
// Once in MEM_WAIT, the wait ends in the first cycle with mem_data_ok=1.
//
// DIV_CYCLES must lie in 2..63. div_cnt holds the remaining divide cycles;
// the cycle in which it reads 1 is the completing cycle and is not stalled,
// so a divide holds ID/EX for DIV_CYCLES-1 cycles, start cycle included.

module pipe_ctrl #(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       fetch_pend,
    input  logic       id_load_use,
    input  logic       ex_div_start,
    input  logic       mem_data_req,
    input  logic       mem_data_ok,
    input  logic       exc_flush,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       id_ex_stall,
    output logic       ex_mem_stall,
    output logic       mem_wb_stall,
    output logic       if_id_refresh,
    output logic       id_ex_refresh,
    output logic       ex_mem_refresh,
    output logic       mem_wb_refresh,
    output logic [1:0] ctrl_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        DIV_WAIT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    state_t     state, state_nxt;
    logic [5:0] div_cnt, div_cnt_nxt;
    logic       flush_pend, flush_pend_nxt;

    // One-hot "what the pipeline is doing this cycle" flags; the strobes
    // below are decoded from these so stall monotonicity holds by design.
    logic do_flush, do_mem, do_div, do_ldu, do_fetch;
    logic mem_miss;

    assign mem_miss = mem_data_req & ~mem_data_ok;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            div_cnt    <= 6'd0;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            div_cnt    <= div_cnt_nxt;
            flush_pend <= flush_pend_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        div_cnt_nxt    = div_cnt;
        flush_pend_nxt = flush_pend;
        do_flush       = 1'b0;
        do_mem         = 1'b0;
        do_div         = 1'b0;
        do_ldu         = 1'b0;
        do_fetch       = 1'b0;

        case (state)
            IDLE: begin
                if (exc_flush) begin
                    // Flush is applied in place; no extra FLUSH cycle.
                    do_flush = 1'b1;
                end else if (mem_miss) begin
                    do_mem    = 1'b1;
                    state_nxt = MEM_WAIT;
                end else if (ex_div_start) begin
                    do_div      = 1'b1;
                    state_nxt   = DIV_WAIT;
                    div_cnt_nxt = DIV_LOAD;
                end else if (id_load_use) begin
                    do_ldu = 1'b1;
                end else if (fetch_pend) begin
                    do_fetch = 1'b1;
                end
            end

            MEM_WAIT: begin
                if (!mem_data_ok) begin
                    do_mem = 1'b1;
                    // The access in MEM cannot be dropped mid-flight, so the
                    // flush is remembered and replayed once it completes.
                    if (exc_flush) begin
                        flush_pend_nxt = 1'b1;
                    end
                end else begin
                    state_nxt      = (flush_pend || exc_flush) ? FLUSH : IDLE;
                    flush_pend_nxt = 1'b0;
                end
            end

            DIV_WAIT: begin
                if (exc_flush) begin
                    do_flush    = 1'b1;
                    div_cnt_nxt = 6'd0;
                    state_nxt   = IDLE;
                end else if (div_cnt > 6'd1) begin
                    do_div      = 1'b1;
                    div_cnt_nxt = div_cnt - 6'd1;
                end else begin
                    // Completing cycle: result is written, stalls released.
                    div_cnt_nxt = 6'd0;
                    state_nxt   = IDLE;
                end
            end

            FLUSH: begin
                do_flush  = 1'b1;
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Outputs are forced low while reset is asserted, independent of clk.
        if (!resetn) begin
            do_flush = 1'b0;
            do_mem   = 1'b0;
            do_div   = 1'b0;
            do_ldu   = 1'b0;
            do_fetch = 1'b0;
        end
    end

    assign pc_stall       = do_mem | do_div | do_ldu | do_fetch;
    assign if_id_stall    = do_mem | do_div | do_ldu;
    assign id_ex_stall    = do_mem | do_div;
    assign ex_mem_stall   = do_mem;
    // MEM/WB is never held: during a memory wait it is fed bubbles instead.
    assign mem_wb_stall   = 1'b0;

    assign if_id_refresh  = do_flush | do_fetch;
    assign id_ex_refresh  = do_flush | do_ldu;
    assign ex_mem_refresh = do_flush | do_div;
    assign mem_wb_refresh = do_flush | do_mem;

    assign ctrl_state     = state;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a table of single-cycle vectors for the
// IDLE priorities and memory-wait/flush sequences, plus hand-written
// sequences for the divide length, divide abort and asynchronous reset.

module tb_pipe_ctrl;

    // Output vector layout:
    // {pc, if_id_s, id_ex_s, ex_mem_s, mem_wb_s, if_id_r, id_ex_r, ex_mem_r, mem_wb_r}
    localparam logic [8:0] NONE = 9'b00000_0000;
    localparam logic [8:0] MEMW = 9'b11110_0001;
    localparam logic [8:0] DIVW = 9'b11100_0010;
    localparam logic [8:0] LDU  = 9'b11000_0100;
    localparam logic [8:0] FET  = 9'b10000_1000;
    localparam logic [8:0] FLS  = 9'b00000_1111;

    // Input vector layout:
    // {fetch_pend, id_load_use, ex_div_start, mem_data_req, mem_data_ok, exc_flush}
    typedef struct {
        string      name;
        logic [5:0] in;
        logic [8:0] exp;
        logic [1:0] st;
    } vec_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic       fetch_pend, id_load_use, ex_div_start;
    logic       mem_data_req, mem_data_ok, exc_flush;
    logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
    logic       if_id_refresh, id_ex_refresh, ex_mem_refresh, mem_wb_refresh;
    logic [1:0] ctrl_state;

    int n_cmp = 0;
    int n_err = 0;
    vec_t vecs[$];

    pipe_ctrl #(.DIV_CYCLES(32)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .fetch_pend     (fetch_pend),
        .id_load_use    (id_load_use),
        .ex_div_start   (ex_div_start),
        .mem_data_req   (mem_data_req),
        .mem_data_ok    (mem_data_ok),
        .exc_flush      (exc_flush),
        .pc_stall       (pc_stall),
        .if_id_stall    (if_id_stall),
        .id_ex_stall    (id_ex_stall),
        .ex_mem_stall   (ex_mem_stall),
        .mem_wb_stall   (mem_wb_stall),
        .if_id_refresh  (if_id_refresh),
        .id_ex_refresh  (id_ex_refresh),
        .ex_mem_refresh (ex_mem_refresh),
        .mem_wb_refresh (mem_wb_refresh),
        .ctrl_state     (ctrl_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic drive(input logic [5:0] i);
        {fetch_pend, id_load_use, ex_div_start, mem_data_req, mem_data_ok, exc_flush} = i;
    endtask

    task automatic add(input string n, input logic [5:0] i, input logic [8:0] e,
                       input logic [1:0] s);
        vec_t v;
        v.name = n;
        v.in   = i;
        v.exp  = e;
        v.st   = s;
        vecs.push_back(v);
    endtask

    // Scoreboard comparison
    task automatic check(input string n, input logic [8:0] exp, input logic [1:0] st);
        logic [8:0] act;
        act = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
               if_id_refresh, id_ex_refresh, ex_mem_refresh, mem_wb_refresh};
        n_cmp++;
        if (act !== exp || ctrl_state !== st) begin
            n_err++;
            $display("FAIL %s: got outputs=%b state=%0d, required outputs=%b state=%0d",
                     n, act, ctrl_state, exp, st);
        end
    endtask

    task automatic check_int(input string n, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", n, act, exp);
        end
    endtask

    initial begin
        int stall_cycles;

        // IDLE priorities
        add("idle",            6'b000000, NONE, 2'd0);
        add("fetch_pend",      6'b100000, FET,  2'd0);
        add("load_use",        6'b010000, LDU,  2'd0);
        add("ldu_and_fetch",   6'b110000, LDU,  2'd0);
        add("req_ok_same",     6'b000110, NONE, 2'd0);
        add("idle_flush_all",  6'b110101, FLS,  2'd0);
        add("after_flush",     6'b000000, NONE, 2'd0);
        // Three-cycle memory miss
        add("miss_c1",         6'b000100, MEMW, 2'd0);
        add("miss_c2_ignore",  6'b110100, MEMW, 2'd1);
        add("miss_c3",         6'b000100, MEMW, 2'd1);
        add("miss_ok",         6'b000110, NONE, 2'd1);
        add("miss_idle",       6'b000000, NONE, 2'd0);
        // Flush raised during a memory wait
        add("mf_c1",           6'b000100, MEMW, 2'd0);
        add("mf_c2_exc",       6'b000101, MEMW, 2'd1);
        add("mf_c3",           6'b000100, MEMW, 2'd1);
        add("mf_c4_ok",        6'b000110, NONE, 2'd1);
        add("mf_c5_flush",     6'b110100, FLS,  2'd3);
        add("mf_c6_idle",      6'b000000, NONE, 2'd0);
        // Flush coinciding with completion
        add("mok_c1",          6'b000100, MEMW, 2'd0);
        add("mok_exc_ok",      6'b000111, NONE, 2'd1);
        add("mok_flush",       6'b000000, FLS,  2'd3);
        add("mok_idle",        6'b000000, NONE, 2'd0);
        // Flush beats divide start; miss beats divide start
        add("exc_over_div",    6'b001001, FLS,  2'd0);
        add("no_div_started",  6'b000000, NONE, 2'd0);
        add("miss_over_div",   6'b001100, MEMW, 2'd0);
        add("miss_over_div_ok",6'b000110, NONE, 2'd1);
        add("miss_over_div_i", 6'b000000, NONE, 2'd0);

        // Reset: outputs low even with a hazard input present
        resetn = 1'b0;
        drive(6'b110100);
        #12;
        check("reset_gated", NONE, 2'd0);
        drive(6'b000000);
        @(negedge clk);
        resetn = 1'b1;

        // Table-driven vectors
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].in);
            #1;
            check(vecs[i].name, vecs[i].exp, vecs[i].st);
        end

        // Divide: 31 stall cycles including start; fetch/load-use ignored
        stall_cycles = 0;
        @(negedge clk);
        drive(6'b001000);
        #1;
        check("div_start", DIVW, 2'd0);
        if (id_ex_stall === 1'b1) stall_cycles++;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            drive((k >= 5 && k <= 8) ? 6'b110000 : 6'b000000);
            #1;
            if (id_ex_stall === 1'b1) stall_cycles++;
            if (k <= 30)      check($sformatf("div_wait_%0d", k), DIVW, 2'd2);
            else if (k == 31) check("div_release", NONE, 2'd2);
            else              check("div_idle", NONE, 2'd0);
        end
        check_int("div_stall_len", stall_cycles, 31);

        // Divide aborted by a flush when div_cnt = 10
        @(negedge clk);
        drive(6'b001000);
        #1;
        check("abort_start", DIVW, 2'd0);
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            drive(6'b000000);
        end
        #1;
        check("abort_pre", DIVW, 2'd2);
        @(negedge clk);
        drive(6'b000001);
        #1;
        check("abort_flush", FLS, 2'd2);
        @(negedge clk);
        drive(6'b000000);
        #1;
        check("abort_idle", NONE, 2'd0);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        drive(6'b001000);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            drive(6'b000000);
        end
        #1;
        check("rst_pre", DIVW, 2'd2);
        #2;
        drive(6'b101000);
        resetn = 1'b0;
        #1;
        check("rst_async", NONE, 2'd0);
        @(negedge clk);
        #1;
        check("rst_held", NONE, 2'd0);
        drive(6'b000000);
        resetn = 1'b1;
        #1;
        check("rst_release", NONE, 2'd0);
        @(negedge clk);
        #1;
        check("rst_after", NONE, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
